// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes SCLK/LRCLK/SDATA into clk and assembles
// left/right PCM words, publishing a pair with a one-cycle sample strobe.
module i2s_rx #(
    parameter int AUDIO_DW = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                sample,
    output logic                locked,
    output logic                short_word
);

    localparam int NW = $clog2(AUDIO_DW + 2);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [NW-1:0] N_FULL  = NW'(AUDIO_DW);
    localparam logic [NW-1:0] N_SAT   = NW'(AUDIO_DW + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(1);

    // state | meaning
    // HUNT  | no framing; waiting for the first ws transition
    // SYNC  | assembling the first full slot, which is discarded
    // LOCK  | slots committed, pairs delivered
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    logic                sclk_m_q, sclk_s_q, sclk_d_q;
    logic                ws_m_q, ws_s_q;
    logic                sd_m_q, sd_s_q;

    state_t              state_q, state_d;
    logic [NW-1:0]       n_q, n_d;
    logic [AUDIO_DW-1:0] shift_q, shift_d;
    logic                ws_prev_q, ws_prev_d;
    logic [AUDIO_DW-1:0] left_hold_q, left_hold_d;
    logic [AUDIO_DW-1:0] left_chan_q, left_chan_d;
    logic [AUDIO_DW-1:0] right_chan_q, right_chan_d;
    logic                pair_q, pair_d;
    logic                short_pend_q, short_pend_d;
    logic                sample_q, sample_d;
    logic                short_word_q, short_word_d;
    logic                locked_q, locked_d;
    logic [WW-1:0]       wd_q, wd_d;

    logic                rise;
    logic                expire;
    logic [NW-1:0]       n_inc;
    logic [AUDIO_DW-1:0] shift_ins;

    always_comb begin
        rise   = sclk_s_q & ~sclk_d_q;
        expire = ~rise & (wd_q == WD_LAST);
        n_inc  = (n_q == N_SAT) ? n_q : n_q + 1'b1;

        // Bit n of the slot lands at position AUDIO_DW-n; n past AUDIO_DW is dropped.
        shift_ins = shift_q;
        for (int i = 0; i < AUDIO_DW; i++) begin
            if (n_inc == NW'(AUDIO_DW - i)) begin
                shift_ins[i] = sd_s_q;
            end
        end

        state_d      = state_q;
        n_d          = n_q;
        shift_d      = shift_q;
        ws_prev_d    = ws_prev_q;
        left_hold_d  = left_hold_q;
        left_chan_d  = left_chan_q;
        right_chan_d = right_chan_q;
        locked_d     = locked_q;
        pair_d       = 1'b0;
        short_pend_d = 1'b0;
        wd_d         = wd_q;

        if (rise) begin
            wd_d = WD_LOAD;
        end else if (wd_q != '0) begin
            wd_d = wd_q - 1'b1;
        end

        if (rise) begin
            if (ws_s_q != ws_prev_q) begin
                n_d       = '0;
                shift_d   = '0;
                ws_prev_d = ws_s_q;
                case (state_q)
                    HUNT: state_d = SYNC;
                    SYNC: begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                    end
                    LOCK: begin
                        if (!ws_prev_q) begin
                            left_hold_d = shift_ins;
                        end else begin
                            left_chan_d  = left_hold_q;
                            right_chan_d = shift_ins;
                            pair_d       = 1'b1;
                        end
                        short_pend_d = (n_inc < N_FULL);
                    end
                    default: begin
                        state_d  = HUNT;
                        locked_d = 1'b0;
                    end
                endcase
            end else begin
                n_d     = n_inc;
                shift_d = shift_ins;
            end
        end else if (expire) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            n_d      = '0;
            shift_d  = '0;
        end

        // Strobes trail the commit by one clk so they line up with the new words.
        sample_d     = pair_q & locked_q;
        short_word_d = short_pend_q & locked_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m_q     <= 1'b0;
            sclk_s_q     <= 1'b0;
            sclk_d_q     <= 1'b0;
            ws_m_q       <= 1'b0;
            ws_s_q       <= 1'b0;
            sd_m_q       <= 1'b0;
            sd_s_q       <= 1'b0;
            state_q      <= HUNT;
            n_q          <= '0;
            shift_q      <= '0;
            ws_prev_q    <= 1'b0;
            left_hold_q  <= '0;
            left_chan_q  <= '0;
            right_chan_q <= '0;
            pair_q       <= 1'b0;
            short_pend_q <= 1'b0;
            sample_q     <= 1'b0;
            short_word_q <= 1'b0;
            locked_q     <= 1'b0;
            wd_q         <= '0;
        end else begin
            sclk_m_q     <= sclk;
            sclk_s_q     <= sclk_m_q;
            sclk_d_q     <= sclk_s_q;
            ws_m_q       <= lrclk;
            ws_s_q       <= ws_m_q;
            sd_m_q       <= sdata;
            sd_s_q       <= sd_m_q;
            state_q      <= state_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            ws_prev_q    <= ws_prev_d;
            left_hold_q  <= left_hold_d;
            left_chan_q  <= left_chan_d;
            right_chan_q <= right_chan_d;
            pair_q       <= pair_d;
            short_pend_q <= short_pend_d;
            sample_q     <= sample_d;
            short_word_q <= short_word_d;
            locked_q     <= locked_d;
            wd_q         <= wd_d;
        end
    end

    assign left_chan  = left_chan_q;
    assign right_chan = right_chan_q;
    assign sample     = sample_q;
    assign locked     = locked_q;
    assign short_word = short_word_q;

endmodule
